// File: rtl/legv8_main_ctrl_if.sv
// legv8_main_ctrl_if
//   Bundle between the LEGv8 main control FSM and the datapath.
//   master : the control unit. It reads instr_opcode, mem_ready and alu_zero,
//            and drives every control strobe, select and debug output.
//   slave  : the datapath / memory side. It drives the status inputs and
//            consumes the control outputs.
//   Signals:
//     instr_opcode[10:0] IR[31:21]; mem_ready memory access done; alu_zero ALU flag
//     ALU_Op[1:0], alu_src_a, alu_src_b[1:0], reg2loc, ir_write, pc_write,
//     pc_src, mem_read, mem_write, mem_to_reg, reg_write, halted, state[3:0]
interface legv8_main_ctrl_if;
    logic [10:0] instr_opcode;
    logic        mem_ready;
    logic        alu_zero;
    logic [1:0]  ALU_Op;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        reg2loc;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic        halted;
    logic [3:0]  state;

    modport master (
        input  instr_opcode, mem_ready, alu_zero,
        output ALU_Op, alu_src_a, alu_src_b, reg2loc, ir_write, pc_write, pc_src,
               mem_read, mem_write, mem_to_reg, reg_write, halted, state
    );

    modport slave (
        output instr_opcode, mem_ready, alu_zero,
        input  ALU_Op, alu_src_a, alu_src_b, reg2loc, ir_write, pc_write, pc_src,
               mem_read, mem_write, mem_to_reg, reg_write, halted, state
    );
endinterface

// File: rtl/legv8_main_ctrl.sv
// legv8_main_ctrl
//   Multi-cycle LEGv8 main control. This is a Moore FSM that steps each
//   instruction through the phases fetch, decode, execute, memory and
//   write-back. Three outputs are not pure Moore:
//     - ir_write and pc_write in FETCH follow mem_ready.
//     - pc_write in CBZ follows alu_zero.
//     - reg2loc follows the opcode class.
//   Ports:
//     clock   rising-edge clock
//     reset_n asynchronous active-low reset; forces the INIT state
//     bus     legv8_main_ctrl_if.master; opcode/status in, control out
module legv8_main_ctrl (
    input  logic                  clock,
    input  logic                  reset_n,
    legv8_main_ctrl_if.master     bus
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_WB_R   = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_WB_LD  = 4'd7,
        S_MEM_WR = 4'd8,
        S_CBZ    = 4'd9,
        S_BR     = 4'd10,
        S_HALT   = 4'd11
    } state_t;

    state_t state_q, state_d;

    // Opcode class decode
    logic is_r, is_ld, is_st, is_cbz, is_b;

    always_comb begin
        is_r   = (bus.instr_opcode == 11'b10001011000) ||
                 (bus.instr_opcode == 11'b11001011000) ||
                 (bus.instr_opcode == 11'b10001010000) ||
                 (bus.instr_opcode == 11'b10101010000);
        is_ld  = (bus.instr_opcode == 11'b11111000010);
        is_st  = (bus.instr_opcode == 11'b11111000000);
        is_cbz = (bus.instr_opcode[10:3] == 8'b10110100);
        is_b   = (bus.instr_opcode[10:5] == 6'b000101);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_INIT;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d        = S_HALT;
        bus.ALU_Op     = 2'b00;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.halted     = 1'b0;
        // Register port 2 reads Rt for the instructions that need Rt's value.
        bus.reg2loc    = is_st || is_cbz;

        case (state_q)
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                // IR load and PC+4 commit only on the cycle the fetch completes.
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                state_d       = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut while decoding.
                bus.alu_src_b = 2'b11;
                if (is_r)                state_d = S_EXEC_R;
                else if (is_ld || is_st) state_d = S_ADDR;
                else if (is_cbz)         state_d = S_CBZ;
                else if (is_b)           state_d = S_BR;
                else                     state_d = S_HALT;
            end
            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.ALU_Op    = 2'b10;
                state_d       = S_WB_R;
            end
            S_WB_R: begin
                bus.reg_write = 1'b1;
                state_d       = S_FETCH;
            end
            S_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                // Only loads and stores reach this state.
                state_d       = is_ld ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                bus.mem_read = 1'b1;
                state_d      = bus.mem_ready ? S_WB_LD : S_MEM_RD;
            end
            S_WB_LD: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEM_WR: begin
                bus.mem_write = 1'b1;
                state_d       = bus.mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_CBZ: begin
                bus.alu_src_a = 1'b1;
                bus.ALU_Op    = 2'b01;
                bus.pc_src    = 1'b1;
                bus.pc_write  = bus.alu_zero;
                state_d       = S_FETCH;
            end
            S_BR: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = 1'b1;
                state_d      = S_FETCH;
            end
            S_HALT: begin
                bus.halted = 1'b1;
                state_d    = S_HALT;
            end
            default: state_d = S_HALT;
        endcase
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_legv8_main_ctrl.sv
// tb_legv8_main_ctrl
//   Directed test of the LEGv8 main control FSM. The control outputs are
//   packed into one vector and compared with hand-built constants,
//   together with the state encoding.
module tb_legv8_main_ctrl;
    logic clock = 1'b0;
    logic reset_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_B    = 11'b00010110101;
    localparam logic [10:0] OP_ILL  = 11'b00000000000;

    legv8_main_ctrl_if bus ();

    legv8_main_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    logic [13:0] outs;
    assign outs = {bus.ALU_Op, bus.alu_src_a, bus.alu_src_b, bus.reg2loc, bus.ir_write,
                   bus.pc_write, bus.pc_src, bus.mem_read, bus.mem_write, bus.mem_to_reg,
                   bus.reg_write, bus.halted};

    function automatic logic [13:0] ov(input logic [1:0] op, input logic sa,
                                       input logic [1:0] sb, input logic r2l,
                                       input logic irw, input logic pcw, input logic pcs,
                                       input logic mrd, input logic mwr, input logic m2r,
                                       input logic rw, input logic h);
        return {op, sa, sb, r2l, irw, pcw, pcs, mrd, mwr, m2r, rw, h};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] st, input logic [13:0] o);
        n_chk++;
        assert (bus.state === st) else begin
            n_fail++;
            $error("FAIL %s state: observed %0d expected %0d", tag, bus.state, st);
        end
        n_chk++;
        assert (outs === o) else begin
            n_fail++;
            $error("FAIL %s outs: observed %b expected %b", tag, outs, o);
        end
    endtask

    initial begin
        reset_n          = 1'b0;
        bus.instr_opcode = OP_STUR;
        bus.mem_ready    = 1'b1;
        bus.alu_zero     = 1'b0;
        tick(); tick();
        // In reset: only reg2loc is allowed to move, and it follows the opcode.
        chk("rst_stur", 4'd0, ov(2'b00,0,2'b00,1,0,0,0,0,0,0,0,0));
        bus.instr_opcode = OP_ADD; #1;
        chk("rst_add", 4'd0, ov(2'b00,0,2'b00,0,0,0,0,0,0,0,0,0));
        reset_n = 1'b1; #1;
        chk("rel_init", 4'd0, 14'd0);

        // ADD, including a fetch wait state
        tick();
        chk("fetch", 4'd1, ov(2'b00,0,2'b01,0,1,1,0,1,0,0,0,0));
        bus.mem_ready = 1'b0; #1;
        chk("fetch_wait", 4'd1, ov(2'b00,0,2'b01,0,0,0,0,1,0,0,0,0));
        tick();
        chk("fetch_hold", 4'd1, ov(2'b00,0,2'b01,0,0,0,0,1,0,0,0,0));
        bus.mem_ready = 1'b1; #1;
        tick();
        chk("add_dec", 4'd2, ov(2'b00,0,2'b11,0,0,0,0,0,0,0,0,0));
        tick();
        chk("add_exec", 4'd3, ov(2'b10,1,2'b00,0,0,0,0,0,0,0,0,0));
        tick();
        chk("add_wb", 4'd4, ov(2'b00,0,2'b00,0,0,0,0,0,0,0,1,0));
        tick();
        chk("add_fetch", 4'd1, ov(2'b00,0,2'b01,0,1,1,0,1,0,0,0,0));

        // LDUR with two wait cycles in MEM_RD
        bus.instr_opcode = OP_LDUR;
        tick();
        chk("ld_dec", 4'd2, ov(2'b00,0,2'b11,0,0,0,0,0,0,0,0,0));
        bus.mem_ready = 1'b0;
        tick();
        chk("ld_addr", 4'd5, ov(2'b00,1,2'b10,0,0,0,0,0,0,0,0,0));
        tick();
        chk("ld_mem1", 4'd6, ov(2'b00,0,2'b00,0,0,0,0,1,0,0,0,0));
        tick();
        chk("ld_mem2", 4'd6, ov(2'b00,0,2'b00,0,0,0,0,1,0,0,0,0));
        tick();
        chk("ld_mem3", 4'd6, ov(2'b00,0,2'b00,0,0,0,0,1,0,0,0,0));
        bus.mem_ready = 1'b1;
        tick();
        chk("ld_wb", 4'd7, ov(2'b00,0,2'b00,0,0,0,0,0,0,1,1,0));
        tick();
        chk("ld_fetch", 4'd1, ov(2'b00,0,2'b01,0,1,1,0,1,0,0,0,0));

        // CBZ taken, then not taken
        bus.instr_opcode = OP_CBZ;
        bus.alu_zero     = 1'b1; #1;
        chk("cbz_fetch", 4'd1, ov(2'b00,0,2'b01,1,1,1,0,1,0,0,0,0));
        tick();
        chk("cbz_dec", 4'd2, ov(2'b00,0,2'b11,1,0,0,0,0,0,0,0,0));
        tick();
        chk("cbz_taken", 4'd9, ov(2'b01,1,2'b00,1,0,1,1,0,0,0,0,0));
        bus.alu_zero = 1'b0; #1;
        chk("cbz_mealy", 4'd9, ov(2'b01,1,2'b00,1,0,0,1,0,0,0,0,0));
        tick(); tick();
        chk("cbz_dec2", 4'd2, ov(2'b00,0,2'b11,1,0,0,0,0,0,0,0,0));
        tick();
        chk("cbz_ntaken", 4'd9, ov(2'b01,1,2'b00,1,0,0,1,0,0,0,0,0));
        tick();
        chk("cbz_fetch2", 4'd1, ov(2'b00,0,2'b01,1,1,1,0,1,0,0,0,0));

        // B
        bus.instr_opcode = OP_B;
        tick();
        chk("b_dec", 4'd2, ov(2'b00,0,2'b11,0,0,0,0,0,0,0,0,0));
        tick();
        chk("b_br", 4'd10, ov(2'b00,0,2'b00,0,0,1,1,0,0,0,0,0));
        tick();
        chk("b_fetch", 4'd1, ov(2'b00,0,2'b01,0,1,1,0,1,0,0,0,0));

        // STUR stalled in MEM_WR, aborted by async reset
        bus.instr_opcode = OP_STUR;
        tick();
        chk("st_dec", 4'd2, ov(2'b00,0,2'b11,1,0,0,0,0,0,0,0,0));
        bus.mem_ready = 1'b0;
        tick();
        chk("st_addr", 4'd5, ov(2'b00,1,2'b10,1,0,0,0,0,0,0,0,0));
        tick();
        chk("st_mem1", 4'd8, ov(2'b00,0,2'b00,1,0,0,0,0,1,0,0,0));
        tick();
        chk("st_mem2", 4'd8, ov(2'b00,0,2'b00,1,0,0,0,0,1,0,0,0));
        #2 reset_n = 1'b0; #1;
        chk("st_abort", 4'd0, ov(2'b00,0,2'b00,1,0,0,0,0,0,0,0,0));
        tick();
        reset_n       = 1'b1;
        bus.mem_ready = 1'b1;
        tick();
        chk("st_refetch", 4'd1, ov(2'b00,0,2'b01,1,1,1,0,1,0,0,0,0));

        // Illegal opcode traps and stays trapped
        bus.instr_opcode = OP_ILL;
        tick();
        chk("ill_dec", 4'd2, ov(2'b00,0,2'b11,0,0,0,0,0,0,0,0,0));
        tick();
        chk("halt", 4'd11, ov(2'b00,0,2'b00,0,0,0,0,0,0,0,0,1));
        for (int i = 0; i < 20; i++) begin
            bus.mem_ready = 1'($urandom_range(0, 1));
            bus.alu_zero  = 1'($urandom_range(0, 1));
            tick();
            chk($sformatf("halt_%0d", i), 4'd11, ov(2'b00,0,2'b00,0,0,0,0,0,0,0,0,1));
        end
        reset_n = 1'b0; #1;
        chk("halt_rst", 4'd0, 14'd0);
        tick();
        reset_n       = 1'b1;
        bus.mem_ready = 1'b1;
        tick();
        chk("halt_refetch", 4'd1, ov(2'b00,0,2'b01,0,1,1,0,1,0,0,0,0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
